// File: rtl/bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_pkg : shared types and constants for the 8088-style bus controller    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package bus_pkg;

    typedef enum logic [1:0] {
        MEMRD = 2'd0,
        MEMWR = 2'd1,
        IORD  = 2'd2,
        IOWR  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        TW     = 3'd4,
        T4     = 3'd5,
        HOLDST = 3'd6
    } state_t;

    localparam int WAIT_MAX_DEFAULT = 16;

    localparam logic ALE_RST = 1'b0;
    localparam logic RD_RST  = 1'b1;
    localparam logic WR_RST  = 1'b1;
    localparam logic DEN_RST = 1'b1;
    localparam logic DTR_RST = 1'b1;
    localparam logic IOM_RST = 1'b0;

    // Bit 0 of the op encoding distinguishes write (1) from read (0).
    function automatic logic op_is_read(input op_t op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_wait_timer : wait-state counter with clear/enable and expiry flag     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module bus_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             CW   = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]  LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (en) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign expired = (wait_cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_cycle_ctrl : minimum-mode 8088 bus cycle sequencer with HOLD/HLDA     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        req_valid,
    input  op_t         req_op,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ack,
    output logic [7:0]  rdata,
    output logic        err,
    output logic [7:0]  AD_out,
    input  logic [7:0]  AD_in,
    output logic        AD_oe,
    output logic [11:0] A,
    output logic        ALE,
    output logic        RD,
    output logic        WR,
    output logic        IOM,
    output logic        DTR,
    output logic        DEN,
    input  logic        READY,
    input  logic        HOLD,
    output logic        HLDA
);

    state_t     state;
    op_t        op_q;
    logic [7:0] wdata_q;

    logic is_read, expired, timeout, done;
    logic at_boundary, grant_hold, accept;
    logic wait_clr, wait_en;

    assign is_read     = op_is_read(op_q);
    // HOLD and new requests are only considered between cycles.
    assign at_boundary = (state == IDLE) || (state == T4);
    assign grant_hold  = at_boundary && HOLD;
    assign accept      = at_boundary && !HOLD && req_valid;
    assign timeout     = (state == TW) && !READY && expired;
    assign done        = ((state == T3) || (state == TW)) && (READY || timeout);
    assign wait_clr    = (state == T3);
    assign wait_en     = (state == TW) && !READY && !expired;

    bus_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            op_q    <= MEMRD;
            wdata_q <= '0;
            ALE     <= ALE_RST;
            RD      <= RD_RST;
            WR      <= WR_RST;
            DEN     <= DEN_RST;
            DTR     <= DTR_RST;
            IOM     <= IOM_RST;
            AD_oe   <= 1'b0;
            AD_out  <= '0;
            A       <= '0;
            HLDA    <= 1'b0;
            req_ack <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            req_ack <= 1'b0;
            case (state)
                IDLE: state <= IDLE;
                T1: begin
                    state <= T2;
                    ALE   <= 1'b0;
                    DEN   <= 1'b0;
                    if (is_read) begin
                        AD_oe <= 1'b0;
                        RD    <= 1'b0;
                    end else begin
                        AD_out <= wdata_q;
                        WR     <= 1'b0;
                    end
                end
                T2: state <= T3;
                T3, TW: begin
                    if (done) begin
                        state   <= T4;
                        RD      <= 1'b1;
                        WR      <= 1'b1;
                        DEN     <= 1'b1;
                        AD_oe   <= 1'b0;
                        req_ack <= 1'b1;
                        err     <= timeout;
                        if (is_read) begin
                            rdata <= timeout ? 8'hFF : AD_in;
                        end
                    end else begin
                        state <= TW;
                    end
                end
                T4: begin
                    state <= IDLE;
                    err   <= 1'b0;
                end
                HOLDST: begin
                    if (!HOLD) begin
                        state <= IDLE;
                        HLDA  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Boundary decisions override the per-state next state above.
            if (grant_hold) begin
                state <= HOLDST;
                HLDA  <= 1'b1;
            end else if (accept) begin
                state   <= T1;
                op_q    <= req_op;
                wdata_q <= req_wdata;
                ALE     <= 1'b1;
                AD_oe   <= 1'b1;
                AD_out  <= req_addr[7:0];
                A       <= req_op[1] ? {4'h0, req_addr[15:8]} : req_addr[19:8];
                IOM     <= req_op[1];
                DTR     <= req_op[0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bus_cycle_ctrl : directed self-checking bench for bus_cycle_ctrl       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_bus_cycle_ctrl;
    import bus_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        req_valid;
    op_t         req_op;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ack;
    logic [7:0]  rdata;
    logic        err;
    logic [7:0]  AD_out;
    logic [7:0]  AD_in;
    logic        AD_oe;
    logic [11:0] A;
    logic        ALE, RD, WR, IOM, DTR, DEN;
    logic        READY, HOLD, HLDA;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    bus_cycle_ctrl #(.WAIT_MAX(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .rdata(rdata), .err(err),
        .AD_out(AD_out), .AD_in(AD_in), .AD_oe(AD_oe), .A(A),
        .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .DTR(DTR), .DEN(DEN),
        .READY(READY), .HOLD(HOLD), .HLDA(HLDA)
    );

    // {ALE, RD, WR, DEN, AD_oe, IOM, DTR, HLDA, req_ack}
    logic [8:0] strb;
    assign strb = {ALE, RD, WR, DEN, AD_oe, IOM, DTR, HLDA, req_ack};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic request(input op_t op, input logic [19:0] addr, input logic [7:0] wd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    initial begin
        RESET_N = 1'b0; req_valid = 1'b0; req_op = MEMRD; req_addr = '0; req_wdata = '0;
        AD_in = '0; READY = 1'b1; HOLD = 1'b0;
        step(); step();
        check("reset_strobes", 32'(strb), 32'(9'b0_1_1_1_0_0_1_0_0));
        check("reset_bus", {4'h0, A, AD_out, rdata}, {4'h0, 12'h000, 8'h00, 8'h00});
        check("reset_err", 32'(err), 32'd0);
        RESET_N = 1'b1;
        step();

        // MEMRD 8_1234, zero wait
        request(MEMRD, 20'h8_1234, 8'h00);
        AD_in = 8'hEE;
        step();
        check("rd_t1_strobes", 32'(strb), 32'(9'b1_1_1_1_1_0_0_0_0));
        check("rd_t1_addr", {12'h000, A, AD_out}, {12'h000, 12'h812, 8'h34});
        step();
        check("rd_t2_strobes", 32'(strb), 32'(9'b0_0_1_0_0_0_0_0_0));
        step();
        check("rd_t3_strobes", 32'(strb), 32'(9'b0_0_1_0_0_0_0_0_0));
        AD_in = 8'h5A;
        step();
        check("rd_t4_strobes", 32'(strb), 32'(9'b0_1_1_1_0_0_0_0_1));
        check("rd_t4_data", {23'h0, err, rdata}, {23'h0, 1'b0, 8'h5A});
        check("rd_t4_addr_hold", 32'(A), 32'(12'h812));
        req_valid = 1'b0; AD_in = 8'h00;
        step();
        check("rd_idle_strobes", 32'(strb), 32'(9'b0_1_1_1_0_0_0_0_0));
        check("rd_rdata_held", 32'(rdata), 32'(8'h5A));

        // IOWR FF0F, data C3
        request(IOWR, 20'h0_FF0F, 8'hC3);
        step();
        check("io_t1_strobes", 32'(strb), 32'(9'b1_1_1_1_1_1_1_0_0));
        check("io_t1_addr", {12'h000, A, AD_out}, {12'h000, 12'h0FF, 8'h0F});
        step();
        check("io_t2_strobes", 32'(strb), 32'(9'b0_1_0_0_1_1_1_0_0));
        check("io_t2_data", 32'(AD_out), 32'(8'hC3));
        step();
        check("io_t3_strobes", 32'(strb), 32'(9'b0_1_0_0_1_1_1_0_0));
        step();
        check("io_t4_strobes", 32'(strb), 32'(9'b0_1_1_1_0_1_1_0_1));
        check("io_t4_rdata_kept", {23'h0, err, rdata}, {23'h0, 1'b0, 8'h5A});
        req_valid = 1'b0;
        step();

        // MEMRD with three wait states
        request(MEMRD, 20'h0_0100, 8'h00);
        READY = 1'b0; AD_in = 8'h11;
        step(); step(); step();
        for (int c = 4; c <= 6; c++) begin
            step();
            check($sformatf("wait3_tw_c%0d", c), 32'(strb), 32'(9'b0_0_1_0_0_0_0_0_0));
        end
        READY = 1'b1; AD_in = 8'h77;
        step();
        check("wait3_t4_strobes", 32'(strb), 32'(9'b0_1_1_1_0_0_0_0_1));
        check("wait3_t4_data", {23'h0, err, rdata}, {23'h0, 1'b0, 8'h77});
        req_valid = 1'b0;
        step();

        // READY stuck low: timeout after 16 TW, then back-to-back MEMWR
        request(MEMRD, 20'h2_0000, 8'h00);
        READY = 1'b0; AD_in = 8'h33;
        step(); step(); step();
        begin
            int early = 0;
            for (int i = 0; i < 16; i++) begin
                step();
                if (req_ack !== 1'b0 || RD !== 1'b0) early++;
            end
            check("stuck_16_tw", 32'(early), 32'd0);
        end
        step();
        check("stuck_t4_strobes", 32'(strb), 32'(9'b0_1_1_1_0_0_0_0_1));
        check("stuck_t4_err_data", {23'h0, err, rdata}, {23'h0, 1'b1, 8'hFF});
        READY = 1'b1;
        request(MEMWR, 20'h3_4567, 8'h99);
        step();
        check("b2b_t1_strobes", 32'(strb), 32'(9'b1_1_1_1_1_0_1_0_0));
        check("b2b_t1_addr", {11'h000, err, A, AD_out}, {11'h000, 1'b0, 12'h345, 8'h67});
        step();
        check("b2b_t2_strobes", 32'(strb), 32'(9'b0_1_0_0_1_0_1_0_0));
        check("b2b_t2_data", 32'(AD_out), 32'(8'h99));
        step(); step();
        check("b2b_t4_strobes", 32'(strb), 32'(9'b0_1_1_1_0_0_1_0_1));
        check("b2b_t4_err", 32'(err), 32'd0);
        req_valid = 1'b0;
        step();

        // HOLD raised in T2 with a second request queued
        request(MEMRD, 20'h0_0AA0, 8'h00);
        AD_in = 8'h42;
        step(); step();
        HOLD = 1'b1;
        step();
        check("hold_t3_strobes", 32'(strb), 32'(9'b0_0_1_0_0_0_0_0_0));
        step();
        check("hold_t4_strobes", 32'(strb), 32'(9'b0_1_1_1_0_0_0_0_1));
        check("hold_t4_data", 32'(rdata), 32'(8'h42));
        request(MEMWR, 20'h0_0BB1, 8'h5C);
        step();
        check("holdst_strobes", 32'(strb), 32'(9'b0_1_1_1_0_0_0_1_0));
        step();
        check("holdst_stay", 32'(strb), 32'(9'b0_1_1_1_0_0_0_1_0));
        HOLD = 1'b0;
        step();
        check("hold_release_idle", 32'(strb), 32'(9'b0_1_1_1_0_0_0_0_0));
        step();
        check("hold_second_t1", 32'(strb), 32'(9'b1_1_1_1_1_0_1_0_0));
        check("hold_second_addr", 32'(AD_out), 32'(8'hB1));
        step(); step(); step();
        check("hold_second_t4", 32'(strb), 32'(9'b0_1_1_1_0_0_1_0_1));
        req_valid = 1'b0;
        step();

        // Asynchronous reset during TW
        request(MEMRD, 20'h1_2345, 8'h00);
        READY = 1'b0;
        step(); step(); step(); step();
        check("rst_pre_tw", 32'(strb), 32'(9'b0_0_1_0_0_0_0_0_0));
        RESET_N = 1'b0;
        #1;
        check("rst_async_strobes", 32'(strb), 32'(9'b0_1_1_1_0_0_1_0_0));
        check("rst_async_bus", {4'h0, A, AD_out, rdata}, {4'h0, 12'h000, 8'h00, 8'h00});
        step();
        check("rst_hold_no_ack", 32'(strb), 32'(9'b0_1_1_1_0_0_1_0_0));
        req_valid = 1'b0; READY = 1'b1;
        RESET_N = 1'b1;
        step();
        check("rst_idle_no_ack", 32'(req_ack), 32'd0);
        request(MEMWR, 20'h5_0A0B, 8'hE7);
        step();
        check("rst_wr_t1", 32'(strb), 32'(9'b1_1_1_1_1_0_1_0_0));
        check("rst_wr_t1_addr", {12'h000, A, AD_out}, {12'h000, 12'h50A, 8'h0B});
        step(); step(); step();
        check("rst_wr_t4", 32'(strb), 32'(9'b0_1_1_1_0_0_1_0_1));
        check("rst_wr_err", 32'(err), 32'd0);
        req_valid = 1'b0;
        step();
        check("rst_wr_done_idle", 32'(req_ack), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
